alien_fleet_ctrl: RTL and testbench

ALIEN_FLEET_CTRL -- requirements
Module: alien_fleet_ctrl

---
 rtl/alien_fleet_ctrl.sv | 129 ++++++++++++
 tb/tb_alien_fleet_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alien_fleet_ctrl.sv
// alien_fleet_ctrl: fleet movement pacing, kill bookkeeping and round-robin firing
// for a row of aliens.
module alien_fleet_ctrl #(
    parameter int          NUM_ALIENS     = 8,
    parameter logic [15:0] BASE_FREQUENCY = 16'd50000,
    parameter logic [15:0] FREQ_STEP      = 16'd5000,
    parameter logic [15:0] MIN_FREQUENCY  = 16'd5000,
    parameter logic [15:0] MOVE_WIDTH     = 16'd4,
    parameter logic [15:0] FIRE_INTERVAL  = 16'd60000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  game_start,
    input  logic [NUM_ALIENS-1:0] edge_hit,
    input  logic                  hit_valid,
    input  logic [4:0]            hit_index,
    output logic [NUM_ALIENS-1:0] alive,
    output logic                  movement_direction,
    output logic [15:0]           movement_frequency,
    output logic [15:0]           movement_width,
    output logic [NUM_ALIENS-1:0] armed,
    output logic                  drop_pulse,
    output logic                  fleet_cleared
);
    typedef enum logic [1:0] {IDLE, RUN, HOLDOFF, CLEARED} state_t;
    state_t                  state;
    logic [5:0]              count;
    logic [15:0]             fire_cnt;
    logic [16:0]             hold_cnt;
    logic [4:0]              arm_ptr;
    logic                    active, kill, hi_ok, lo_ok, sel_ok;
    logic [NUM_ALIENS-1:0]   kill_mask, alive_next;
    logic [15:0]             freq_next;
    logic [16:0]             freq_floor;
    logic [4:0]              sel_hi, sel_lo, sel;
    assign movement_width = MOVE_WIDTH;
    assign active     = (state == RUN) || (state == HOLDOFF);
    assign kill_mask  = NUM_ALIENS'(1) << hit_index;
    assign kill       = active && hit_valid && (32'(hit_index) < NUM_ALIENS) && |(alive & kill_mask);
    assign alive_next = kill ? (alive & ~kill_mask) : alive;
    assign freq_floor = {1'b0, MIN_FREQUENCY} + {1'b0, FREQ_STEP};
    assign freq_next  = !kill ? movement_frequency :
                        ({1'b0, movement_frequency} < freq_floor) ? MIN_FREQUENCY :
                        movement_frequency - FREQ_STEP;
    // Next shooter: lowest survivor above the pointer, else lowest at or below it.
    always_comb begin
        hi_ok  = 1'b0;
        lo_ok  = 1'b0;
        sel_hi = '0;
        sel_lo = '0;
        for (int i = NUM_ALIENS - 1; i >= 0; i--) begin
            if (alive_next[i] && i > int'(arm_ptr)) begin
                hi_ok  = 1'b1;
                sel_hi = 5'(i);
            end
            if (alive_next[i] && i <= int'(arm_ptr)) begin
                lo_ok  = 1'b1;
                sel_lo = 5'(i);
            end
        end
    end
    assign sel    = hi_ok ? sel_hi : sel_lo;
    assign sel_ok = hi_ok || lo_ok;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            alive              <= '0;
            count              <= '0;
            movement_direction <= 1'b1;
            movement_frequency <= BASE_FREQUENCY;
            armed              <= '0;
            drop_pulse         <= 1'b0;
            fleet_cleared      <= 1'b0;
            fire_cnt           <= '0;
            hold_cnt           <= '0;
            arm_ptr            <= 5'(NUM_ALIENS - 1);
        end else begin
            armed      <= '0;
            drop_pulse <= 1'b0;
            if (!active) begin
                fire_cnt <= '0;
                hold_cnt <= '0;
                if (game_start) begin
                    state              <= RUN;
                    alive              <= '1;
                    count              <= 6'(NUM_ALIENS);
                    movement_direction <= 1'b1;
                    movement_frequency <= BASE_FREQUENCY;
                    arm_ptr            <= 5'(NUM_ALIENS - 1);
                    fleet_cleared      <= 1'b0;
                end
            end else begin
                alive              <= alive_next;
                movement_frequency <= freq_next;
                if (kill)
                    count <= count - 6'd1;
                if (fire_cnt == FIRE_INTERVAL - 16'd1) begin
                    fire_cnt <= '0;
                    if (sel_ok) begin
                        armed   <= NUM_ALIENS'(1) << sel;
                        arm_ptr <= sel;
                    end
                end else begin
                    fire_cnt <= fire_cnt + 16'd1;
                end
                if (state == RUN && |edge_hit) begin
                    movement_direction <= ~movement_direction;
                    drop_pulse         <= 1'b1;
                    hold_cnt           <= {1'b0, movement_frequency} + 17'd1;
                    state              <= HOLDOFF;
                end else if (state == HOLDOFF) begin
                    if (hold_cnt == '0)
                        state <= RUN;
                    else
                        hold_cnt <= hold_cnt - 17'd1;
                end
                // The last kill overrides any same-cycle arming or drop.
                if (kill && count == 6'd1) begin
                    state         <= CLEARED;
                    fleet_cleared <= 1'b1;
                    armed         <= '0;
                    drop_pulse    <= 1'b0;
                    fire_cnt      <= '0;
                    hold_cnt      <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_alien_fleet_ctrl.sv
// tb_alien_fleet_ctrl: directed and random stimulus against a behavioural fleet model.
module tb_alien_fleet_ctrl;
    localparam int N    = 4;
    localparam int BASE = 100;
    localparam int STEP = 30;
    localparam int MINF = 20;
    localparam int FI   = 10;
    localparam int MW   = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_CLR = 3;

    logic         clk, rst_n, game_start, hit_valid;
    logic [N-1:0] edge_hit, alive, armed;
    logic [4:0]   hit_index;
    logic         movement_direction, drop_pulse, fleet_cleared;
    logic [15:0]  movement_frequency, movement_width;

    int n_tests = 0;
    int n_fail  = 0;

    int       m_st, m_freq, m_fire, m_ptr, m_hold;
    bit [3:0] m_alive, m_armed;
    bit       m_dir, m_drop, m_clr;

    alien_fleet_ctrl #(
        .NUM_ALIENS(N), .BASE_FREQUENCY(16'd100), .FREQ_STEP(16'd30),
        .MIN_FREQUENCY(16'd20), .MOVE_WIDTH(16'd4), .FIRE_INTERVAL(16'd10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .game_start(game_start), .edge_hit(edge_hit),
        .hit_valid(hit_valid), .hit_index(hit_index), .alive(alive),
        .movement_direction(movement_direction), .movement_frequency(movement_frequency),
        .movement_width(movement_width), .armed(armed), .drop_pulse(drop_pulse),
        .fleet_cleared(fleet_cleared)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_alive = 0; m_dir = 1; m_freq = BASE; m_fire = 0;
        m_ptr = N - 1; m_hold = 0; m_armed = 0; m_drop = 0; m_clr = 0;
    endtask

    task automatic model_step(input bit gs, input bit [3:0] eh, input bit hv, input int hi);
        int  old_f;
        bit  killed;
        bit  found;
        m_armed = 0;
        m_drop  = 0;
        if (m_st == M_IDLE || m_st == M_CLR) begin
            m_fire = 0;
            m_hold = 0;
            if (gs) begin
                m_alive = 4'hf; m_dir = 1; m_freq = BASE; m_ptr = N - 1;
                m_clr = 0; m_st = M_RUN;
            end
            return;
        end
        old_f  = m_freq;
        killed = hv && hi < N && m_alive[hi];
        if (killed) begin
            m_alive[hi] = 0;
            m_freq = (m_freq - STEP < MINF) ? MINF : m_freq - STEP;
        end
        if (m_fire == FI - 1) begin
            m_fire = 0;
            found  = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && m_alive[(m_ptr + k) % N]) begin
                    found   = 1;
                    m_ptr   = (m_ptr + k) % N;
                    m_armed = 4'(1 << m_ptr);
                end
            end
        end else begin
            m_fire++;
        end
        if (m_st == M_RUN && eh != 0) begin
            m_dir = !m_dir; m_drop = 1; m_hold = old_f + 1; m_st = M_HOLD;
        end else if (m_st == M_HOLD) begin
            if (m_hold == 0) m_st = M_RUN;
            else m_hold--;
        end
        if (killed && m_alive == 0) begin
            m_st = M_CLR; m_clr = 1; m_armed = 0; m_drop = 0; m_fire = 0; m_hold = 0;
        end
    endtask

    task automatic compare_all();
        check("alive", 32'(alive), 32'(m_alive));
        check("direction", 32'(movement_direction), 32'(m_dir));
        check("frequency", 32'(movement_frequency), m_freq);
        check("width", 32'(movement_width), MW);
        check("armed", 32'(armed), 32'(m_armed));
        check("drop_pulse", 32'(drop_pulse), 32'(m_drop));
        check("fleet_cleared", 32'(fleet_cleared), 32'(m_clr));
    endtask

    task automatic cycle(input bit gs, input bit [3:0] eh, input bit hv, input logic [4:0] hi);
        @(negedge clk);
        game_start = gs; edge_hit = eh; hit_valid = hv; hit_index = hi;
        @(posedge clk);
        model_step(gs, eh, hv, int'(hi));
        #1 compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    task automatic sync_reset();
        @(negedge clk);
        rst_n = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0; game_start = 0; edge_hit = 0; hit_valid = 0; hit_index = 0;
        model_reset();
        #12 compare_all();
        @(negedge clk);
        rst_n = 1;
        idle(2);
        check("idle_alive", 32'(alive), 0);

        cycle(1, 0, 0, 0);
        check("start_alive", 32'(alive), 32'hf);
        check("start_freq", 32'(movement_frequency), 100);
        idle(10);
        check("arm_first", 32'(armed), 32'h1);
        idle(10);
        check("arm_second", 32'(armed), 32'h2);

        cycle(0, 4'b0100, 0, 0);
        check("edge_dir", 32'(movement_direction), 0);
        check("edge_drop", 32'(drop_pulse), 1);
        for (int i = 0; i < 8; i++) cycle(0, 4'b0100, 0, 0);
        check("holdoff_dir", 32'(movement_direction), 0);
        check("holdoff_drop", 32'(drop_pulse), 0);
        cycle(0, 0, 1, 5'd2);
        check("coin_armed", 32'(armed), 32'h8);
        check("coin_alive", 32'(alive), 32'hb);
        check("kill2_freq", 32'(movement_frequency), 70);
        idle(100);
        cycle(0, 4'b0001, 0, 0);
        check("edge_again_dir", 32'(movement_direction), 1);

        cycle(0, 0, 1, 5'd0);
        check("kill0_freq", 32'(movement_frequency), 40);
        cycle(0, 0, 1, 5'd1);
        check("kill1_freq", 32'(movement_frequency), 20);
        cycle(0, 0, 1, 5'd1);
        check("rehit_freq", 32'(movement_frequency), 20);
        check("rehit_alive", 32'(alive), 32'h8);
        cycle(0, 0, 1, 5'd7);
        check("oob_alive", 32'(alive), 32'h8);
        cycle(0, 0, 1, 5'd3);
        check("clr_flag", 32'(fleet_cleared), 1);
        check("clr_armed", 32'(armed), 0);
        check("clr_alive", 32'(alive), 0);
        idle(12);
        cycle(1, 0, 0, 0);
        check("restart_alive", 32'(alive), 32'hf);
        check("restart_freq", 32'(movement_frequency), 100);
        check("restart_clr", 32'(fleet_cleared), 0);

        for (int i = 0; i < 1500; i++)
            cycle($urandom_range(0, 49) == 0,
                  ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                  $urandom_range(0, 14) == 0,
                  5'($urandom_range(0, 7)));

        sync_reset();
        cycle(1, 0, 0, 0);
        idle(3);
        cycle(0, 4'b0010, 0, 0);
        idle(20);
        check("in_holdoff_dir", 32'(movement_direction), 0);
        #2 rst_n = 0;
        model_reset();
        #1;
        check("arst_alive", 32'(alive), 0);
        check("arst_dir", 32'(movement_direction), 1);
        check("arst_freq", 32'(movement_frequency), 100);
        check("arst_armed", 32'(armed), 0);
        check("arst_drop", 32'(drop_pulse), 0);
        check("arst_clr", 32'(fleet_cleared), 0);
        @(negedge clk);
        rst_n = 1;
        idle(5);
        cycle(1, 0, 0, 0);
        idle(10);
        check("post_arst_arm", 32'(armed), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
